// File: rtl/exc_sequencer.sv
// Exception entry/return sequencer: saves the EPC, fetches the vector byte from
// memory and loads it into the PC, or restores the PC from the EPC on rte.
module exc_sequencer #(
    parameter int                NUM_CAUSES = 3,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(32'h000000FD),
    parameter int                MEM_LAT    = 2,
    localparam int               CAUSE_W    = (NUM_CAUSES > 1) ? $clog2(NUM_CAUSES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CAUSES-1:0] exc_req,
    input  logic                  rte,
    input  logic [ADDR_W-1:0]     pc_in,
    input  logic [7:0]            mem_data,
    output logic                  mem_rd,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  epc_load,
    output logic [ADDR_W-1:0]     epc_out,
    output logic [ADDR_W-1:0]     pc_out,
    output logic                  pc_write,
    output logic [CAUSE_W-1:0]    cause_out,
    output logic                  exc_active,
    output logic                  exc_done
);

    // Sized so the counter can reach MEM_LAT itself without wrapping.
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE,
        S_READ,
        S_LOAD,
        S_RESTORE
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_CAUSES-1:0] pend_q, pend_d;
    logic [NUM_CAUSES-1:0] pend_all;
    logic [NUM_CAUSES-1:0] first_onehot;
    logic [CAUSE_W-1:0]    cause_q, cause_d;
    logic [CAUSE_W-1:0]    first_idx;
    logic [ADDR_W-1:0]     epc_q, epc_d;
    logic [7:0]            vec_q, vec_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    assign pend_all     = pend_q | exc_req;
    assign first_onehot = pend_all & (~pend_all + NUM_CAUSES'(1));

    // Lowest set index wins; scanning downward leaves the lowest one last.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_CAUSES - 1; i >= 0; i--) begin
            if (pend_all[i]) begin
                first_idx = CAUSE_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            cause_q <= '0;
            epc_q   <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_all;
        cause_d = cause_q;
        epc_d   = epc_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                // A request always beats rte arriving on the same edge.
                if (|pend_all) begin
                    state_d = S_SAVE;
                    cause_d = first_idx;
                    epc_d   = pc_in - ADDR_W'(4);
                    pend_d  = pend_all & ~first_onehot;
                end else if (rte) begin
                    state_d = S_RESTORE;
                end
            end
            S_SAVE: begin
                state_d = S_READ;
                cnt_d   = '0;
            end
            S_READ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
                    vec_d   = mem_data;
                    state_d = S_LOAD;
                end
            end
            S_LOAD:    state_d = S_IDLE;
            S_RESTORE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd     = 1'b0;
        mem_addr   = '0;
        epc_load   = 1'b0;
        pc_out     = '0;
        pc_write   = 1'b0;
        exc_done   = 1'b0;
        exc_active = (state_q != S_IDLE);
        unique case (state_q)
            S_SAVE: epc_load = 1'b1;
            S_READ: begin
                mem_rd   = 1'b1;
                mem_addr = VEC_BASE + ADDR_W'(cause_q);
            end
            S_LOAD: begin
                pc_write = 1'b1;
                pc_out   = ADDR_W'(vec_q);
                exc_done = 1'b1;
            end
            S_RESTORE: begin
                pc_write = 1'b1;
                pc_out   = epc_q;
            end
            default: ;
        endcase
    end

    assign epc_out   = epc_q;
    assign cause_out = cause_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Scoreboard bench for exc_sequencer: default instance plus a MEM_LAT=4,
// NUM_CAUSES=5 instance; memory returns addr[7:0] + 8'h9E.
module tb_exc_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        rte;
    logic        rte_b;
    logic [31:0] pc_in;
    logic [2:0]  exc_req_a;
    logic [4:0]  exc_req_b;
    logic        sel;

    logic        a_mem_rd, a_epc_load, a_pc_write, a_exc_active, a_exc_done;
    logic [31:0] a_mem_addr, a_epc_out, a_pc_out;
    logic [1:0]  a_cause;
    logic [7:0]  a_mem_data;

    logic        b_mem_rd, b_epc_load, b_pc_write, b_exc_active, b_exc_done;
    logic [31:0] b_mem_addr, b_epc_out, b_pc_out;
    logic [2:0]  b_cause;
    logic [7:0]  b_mem_data;

    assign a_mem_data = a_mem_addr[7:0] + 8'h9E;
    assign b_mem_data = b_mem_addr[7:0] + 8'h9E;

    exc_sequencer dut_a (
        .clk        (clk),
        .reset      (reset),
        .exc_req    (exc_req_a),
        .rte        (rte),
        .pc_in      (pc_in),
        .mem_data   (a_mem_data),
        .mem_rd     (a_mem_rd),
        .mem_addr   (a_mem_addr),
        .epc_load   (a_epc_load),
        .epc_out    (a_epc_out),
        .pc_out     (a_pc_out),
        .pc_write   (a_pc_write),
        .cause_out  (a_cause),
        .exc_active (a_exc_active),
        .exc_done   (a_exc_done)
    );

    exc_sequencer #(.NUM_CAUSES(5), .MEM_LAT(4)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .exc_req    (exc_req_b),
        .rte        (rte_b),
        .pc_in      (pc_in),
        .mem_data   (b_mem_data),
        .mem_rd     (b_mem_rd),
        .mem_addr   (b_mem_addr),
        .epc_load   (b_epc_load),
        .epc_out    (b_epc_out),
        .pc_out     (b_pc_out),
        .pc_write   (b_pc_write),
        .cause_out  (b_cause),
        .exc_active (b_exc_active),
        .exc_done   (b_exc_done)
    );

    // Observed instance, selected by sel
    logic        o_mem_rd, o_epc_load, o_pc_write, o_active, o_done;
    logic [31:0] o_mem_addr, o_epc, o_pc_out, o_cause;
    assign o_mem_rd   = sel ? b_mem_rd     : a_mem_rd;
    assign o_epc_load = sel ? b_epc_load   : a_epc_load;
    assign o_pc_write = sel ? b_pc_write   : a_pc_write;
    assign o_active   = sel ? b_exc_active : a_exc_active;
    assign o_done     = sel ? b_exc_done   : a_exc_done;
    assign o_mem_addr = sel ? b_mem_addr   : a_mem_addr;
    assign o_epc      = sel ? b_epc_out    : a_epc_out;
    assign o_pc_out   = sel ? b_pc_out     : a_pc_out;
    assign o_cause    = sel ? 32'(b_cause) : 32'(a_cause);

    typedef struct {
        bit          is_exc;
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] cause;
        logic [31:0] addr;
        int          rd;
        int          act;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input bit is_exc, input logic [31:0] pc, input logic [31:0] epc,
                        input logic [31:0] cause, input logic [31:0] addr,
                        input int rd, input int act);
        exp_t e;
        e.is_exc = is_exc; e.pc = pc; e.epc = epc; e.cause = cause;
        e.addr = addr; e.rd = rd; e.act = act;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic check_a_zero(input string tag);
        chk({tag, "_strobes"}, 32'({a_mem_rd, a_epc_load, a_pc_write, a_exc_done, a_exc_active}), 32'h0);
        chk({tag, "_mem_addr"}, a_mem_addr, 32'h0);
        chk({tag, "_pc_out"}, a_pc_out, 32'h0);
        chk({tag, "_epc_out"}, a_epc_out, 32'h0);
        chk({tag, "_cause"}, 32'(a_cause), 32'h0);
    endtask

    // Monitor: gathers one service run and scores it at the pc_write cycle.
    int          rd_cnt  = 0;
    int          act_cnt = 0;
    int          epc_cnt = 0;
    logic [31:0] rd_addr = '0;

    always @(negedge clk) begin
        if (reset) begin
            rd_cnt = 0; act_cnt = 0; epc_cnt = 0; rd_addr = '0;
        end else begin
            if (!o_active) begin
                chk("idle_strobes", 32'({o_mem_rd, o_epc_load, o_pc_write, o_done}), 32'h0);
                chk("idle_buses", o_mem_addr | o_pc_out, 32'h0);
            end else begin
                act_cnt++;
                chk("done_without_pc_write", 32'(o_done && !o_pc_write), 32'h0);
            end
            if (o_epc_load) epc_cnt++;
            if (o_mem_rd) begin
                if (rd_cnt == 0) rd_addr = o_mem_addr;
                else chk("mem_addr_stable", o_mem_addr, rd_addr);
                rd_cnt++;
            end
            if (o_pc_write) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pc_write actual pc_out=%h required=no write", o_pc_out);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("kind_exc_done", 32'(o_done), 32'(e.is_exc));
                    chk("pc_out", o_pc_out, e.pc);
                    chk("epc_out", o_epc, e.epc);
                    chk("cause_out", o_cause, e.cause);
                    chk("epc_load_pulses", 32'(epc_cnt), e.is_exc ? 32'd1 : 32'd0);
                    chk("read_cycles", 32'(rd_cnt), 32'(e.rd));
                    if (e.is_exc) chk("read_addr", rd_addr, e.addr);
                    chk("active_cycles", 32'(act_cnt), 32'(e.act));
                    $display("txn %s pc_out=%h epc=%h cause=%0d reads=%0d active=%0d",
                             e.is_exc ? "EXC" : "RTE", o_pc_out, o_epc, o_cause, rd_cnt, act_cnt);
                end
                rd_cnt = 0; act_cnt = 0; epc_cnt = 0;
            end
        end
    end

    initial begin
        reset = 1'b1; rte = 1'b0; rte_b = 1'b0; pc_in = '0;
        exc_req_a = '0; exc_req_b = '0; sel = 1'b0;
        #1;
        check_a_zero("reset_init");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Single cause 1 exception
        pc_in = 32'h40;
        push(1, 32'h9C, 32'h3C, 1, 32'hFE, 2, 4);
        exc_req_a = 3'b010; tick(); exc_req_a = '0;
        idle(8);

        // Return from exception
        push(0, 32'h3C, 32'h3C, 1, 32'h0, 0, 1);
        rte = 1'b1; tick(); rte = 1'b0;
        idle(4);

        // Two causes together: 0 first, then 2 from pend
        pc_in = 32'h100;
        push(1, 32'h9B, 32'hFC, 0, 32'hFD, 2, 4);
        push(1, 32'h9D, 32'hFC, 2, 32'hFF, 2, 4);
        exc_req_a = 3'b101; tick(); exc_req_a = '0;
        idle(14);

        // Exception and rte together: rte is dropped
        pc_in = 32'h200;
        push(1, 32'h9B, 32'h1FC, 0, 32'hFD, 2, 4);
        exc_req_a = 3'b001; rte = 1'b1; tick(); exc_req_a = '0; rte = 1'b0;
        idle(10);

        // EPC wraps at pc_in=0; rte while busy is ignored
        pc_in = 32'h0;
        push(1, 32'h9C, 32'hFFFF_FFFC, 1, 32'hFE, 2, 4);
        exc_req_a = 3'b010; tick(); exc_req_a = '0;
        rte = 1'b1; idle(3); rte = 1'b0;
        idle(8);

        // Reset during second READ cycle with cause 2 pending
        pc_in = 32'h300;
        exc_req_a = 3'b001; tick();
        exc_req_a = 3'b100; tick();
        exc_req_a = '0; tick();
        #2 reset = 1'b1;
        #1 check_a_zero("reset_mid_read");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("no_residual_exception", 32'(a_exc_active), 32'h0);
        end

        // Normal service after reset release
        pc_in = 32'h500;
        push(1, 32'h9D, 32'h4FC, 2, 32'hFF, 2, 4);
        exc_req_a = 3'b100; tick(); exc_req_a = '0;
        idle(8);

        // Wide instance: cause 4, four read cycles
        sel = 1'b1;
        pc_in = 32'h1000;
        push(1, 32'h9F, 32'hFFC, 4, 32'h101, 4, 6);
        exc_req_b = 5'b10000; tick(); exc_req_b = '0;
        idle(12);

        chk("scoreboard_empty", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
